localbus_master: RTL and testbench

- Local-bus initiator: drives the 22-bit-address / 8-bit-data local bus that table and control blocks answer as responders.
- Accepts queued read/write commands from control logic (table loader, CPU bridge).
- Runs one bus transaction per command and returns exactly one response per command.
- Holds the command queue and the cs/ack handshake FSM; guards hung responders with a timeout.

---
 rtl/localbus_pkg.sv | 31 +++
 rtl/lb_cmd_fifo.sv | 65 ++++++
 rtl/localbus_master.sv | 160 ++++++++++++++++
 tb/tb_localbus_master.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/localbus_pkg.sv
// Shared types and field layout for the local-bus initiator and its command FIFO.
// The timeout/abort path is built only when LOCALBUS_TIMEOUT_EN is defined.
package localbus_pkg;

  localparam int unsigned LB_ADDR_W = 22;
  localparam int unsigned LB_DATA_W = 8;
  localparam int unsigned CMD_W     = 31;
  localparam int unsigned RSP_W     = 10;
  localparam int unsigned TO_CNT_W  = 16;

  localparam int unsigned RW_BIT   = 30;
  localparam int unsigned ADDR_MSB = 29;
  localparam int unsigned ADDR_LSB = 8;

  localparam int unsigned TO_BIT  = 9;
  localparam int unsigned RRW_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RELEASE  = 2'd3
  } lb_state_e;

  typedef struct packed {
    logic                 timeout;
    logic                 rw;
    logic [LB_DATA_W-1:0] rdata;
  } lb_rsp_t;

endpackage

// File: rtl/lb_cmd_fifo.sv
// Synchronous show-ahead FIFO with registered empty and count-based almost-full flags.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module lb_cmd_fifo #(
  parameter int unsigned WIDTH     = 31,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned ALF_LEVEL = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout_c,
  output logic             empty,
  output logic             alf
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_d;
  logic              full_c;
  logic              push_ok_c;
  logic              pop_ok_c;

  assign full_c    = (count == CNT_W'(DEPTH));
  assign pop_ok_c  = pop && !empty;
  assign push_ok_c = push && (!full_c || pop_ok_c);
  assign dout_c    = mem[rd_ptr];

  always_comb begin
    count_d = count;
    if (push_ok_c && !pop_ok_c) begin
      count_d = count + CNT_W'(1);
    end else if (pop_ok_c && !push_ok_c) begin
      count_d = count - CNT_W'(1);
    end
  end

  // Flags are registered from the next count so they track count with no lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      alf    <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_d;
      empty <= (count_d == '0);
      alf   <= (count_d >= CNT_W'(ALF_LEVEL));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/localbus_master.sv
// Local-bus initiator: queues commands, runs one cs/ack transaction each, returns one response each.
// Define LOCALBUS_TIMEOUT_EN to build the WAIT_ACK timeout counter and abort path.
module localbus_master
  import localbus_pkg::*;
#(
  parameter int unsigned CMD_DEPTH      = 16,
  parameter int unsigned CMD_ADDR_W     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_in_wr,
  input  logic [CMD_W-1:0]     cmd_in,
  output logic                 cmd_out_alf,
  output logic                 rsp_out_wr,
  output logic [RSP_W-1:0]     rsp_out,
  input  logic                 rsp_in_alf,
  output logic                 local_cs_n,
  output logic                 local_rw,
  output logic [LB_ADDR_W-1:0] local_addr,
  output logic [LB_DATA_W-1:0] local_wdata,
  input  logic [LB_DATA_W-1:0] local_rdata,
  input  logic                 local_ack_n
);

  if (CMD_DEPTH != (32'd1 << CMD_ADDR_W) || CMD_DEPTH < 4) begin : g_bad_depth
    $error("CMD_DEPTH must be 2**CMD_ADDR_W and at least 4");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end
  if (TO_BIT != RSP_W - 1 || RRW_BIT != LB_DATA_W || RW_BIT != CMD_W - 1 ||
      ADDR_MSB - ADDR_LSB + 1 != LB_ADDR_W) begin : g_bad_layout
    $error("field offsets inconsistent with bus widths");
  end

  lb_state_e            state_q;
  lb_state_e            state_d;
  logic                 pop_c;
  logic                 done_ack_c;
  logic                 done_to_c;
  logic                 to_hit_c;
  logic                 fifo_empty;
  logic [CMD_W-1:0]     head_c;
  logic                 ack_q;
  logic [LB_DATA_W-1:0] rdata_q;
  lb_rsp_t              rsp_c;

  lb_cmd_fifo #(
    .WIDTH     (CMD_W),
    .DEPTH     (CMD_DEPTH),
    .ADDR_W    (CMD_ADDR_W),
    .ALF_LEVEL (CMD_DEPTH - 2)
  ) u_cmd_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (cmd_in_wr),
    .din    (cmd_in),
    .pop    (pop_c),
    .dout_c (head_c),
    .empty  (fifo_empty),
    .alf    (cmd_out_alf)
  );

`ifdef LOCALBUS_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [TO_CNT_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state_q == ST_ISSUE) begin
      to_cnt <= '0;
    end else if (state_q == ST_WAIT_ACK && !to_hit_c) begin
      to_cnt <= to_cnt + TO_CNT_W'(1);
    end
  end

  assign to_hit_c = (to_cnt == TO_LAST);
`else
  assign to_hit_c = 1'b0;
`endif

  // Ack and read data are sampled one edge before the FSM acts on them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= !local_ack_n;
      rdata_q <= local_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop_c      = 1'b0;
    done_ack_c = 1'b0;
    done_to_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !rsp_in_alf) begin
          pop_c   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (ack_q) begin
          done_ack_c = 1'b1;
          state_d    = ST_RELEASE;
        end else if (to_hit_c) begin
          done_to_c = 1'b1;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (local_ack_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_c         = '0;
    rsp_c.timeout = done_to_c;
    rsp_c.rw      = local_rw;
    if (done_ack_c && local_rw) rsp_c.rdata = rdata_q;
  end

  // Bus and response registers; address/data/rw only move on a pop in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      local_cs_n  <= 1'b1;
      local_rw    <= 1'b1;
      local_addr  <= '0;
      local_wdata <= '0;
      rsp_out_wr  <= 1'b0;
      rsp_out     <= '0;
    end else begin
      rsp_out_wr <= done_ack_c || done_to_c;
      if (pop_c) begin
        local_rw    <= head_c[RW_BIT];
        local_addr  <= head_c[ADDR_MSB:ADDR_LSB];
        local_wdata <= head_c[LB_DATA_W-1:0];
      end
      if (state_q == ST_ISSUE) local_cs_n <= 1'b0;
      if (done_ack_c || done_to_c) begin
        local_cs_n <= 1'b1;
        rsp_out    <= rsp_c;
      end
    end
  end

endmodule

// File: tb/tb_localbus_master.sv
// Directed bench for localbus_master with a transaction-level responder and response model.
// Timeout scenarios run only when LOCALBUS_TIMEOUT_EN is defined.
module tb_localbus_master;

  localparam int TO = 8;

  typedef struct {
    logic        rw;
    logic [21:0] addr;
    logic [7:0]  wdata;
    int          delay;
    logic [7:0]  rdata;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        cmd_in_wr;
  logic [30:0] cmd_in;
  logic        cmd_out_alf;
  logic        rsp_out_wr;
  logic [9:0]  rsp_out;
  logic        rsp_in_alf;
  logic        local_cs_n;
  logic        local_rw;
  logic [21:0] local_addr;
  logic [7:0]  local_wdata;
  logic [7:0]  local_rdata = 8'hEE;
  logic        local_ack_n = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  txn_t       pending[$];
  logic [9:0] rspq[$];

  localbus_master #(
    .CMD_DEPTH      (16),
    .CMD_ADDR_W     (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_in_wr   (cmd_in_wr),
    .cmd_in      (cmd_in),
    .cmd_out_alf (cmd_out_alf),
    .rsp_out_wr  (rsp_out_wr),
    .rsp_out     (rsp_out),
    .rsp_in_alf  (rsp_in_alf),
    .local_cs_n  (local_cs_n),
    .local_rw    (local_rw),
    .local_addr  (local_addr),
    .local_wdata (local_wdata),
    .local_rdata (local_rdata),
    .local_ack_n (local_ack_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // A transaction times out when the responder never acks or acks too late to win.
  function automatic bit timed_out(input int d);
`ifdef LOCALBUS_TIMEOUT_EN
    return (d <= 0) || (d >= TO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [9:0] exp_rsp(input logic rw, input int d, input logic [7:0] rdata);
    if (timed_out(d)) return {1'b1, rw, 8'h00};
    return {1'b0, rw, (rw ? rdata : 8'h00)};
  endfunction

  function automatic int exp_low(input int d);
    return timed_out(d) ? TO : d + 1;
  endfunction

  task automatic drive(input logic rw, input logic [21:0] addr, input logic [7:0] wdata,
                       input int delay, input logic [7:0] rdata, input bit accept);
    txn_t t;
    cmd_in_wr = 1'b1;
    cmd_in    = {rw, addr, wdata};
    if (accept) begin
      t.rw = rw; t.addr = addr; t.wdata = wdata; t.delay = delay; t.rdata = rdata;
      pending.push_back(t);
      rspq.push_back(exp_rsp(rw, delay, rdata));
    end
  endtask

  task automatic push(input logic rw, input logic [21:0] addr, input logic [7:0] wdata,
                      input int delay, input logic [7:0] rdata);
    @(negedge clk);
    drive(rw, addr, wdata, delay, rdata, 1'b1);
  endtask

  task automatic end_push();
    @(negedge clk);
    cmd_in_wr = 1'b0;
  endtask

  task automatic wait_rsp(output logic [9:0] v);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_out_wr && k < 200);
    check("rsp_arrived", 32'(rsp_out_wr), 32'd1);
    v = rsp_out;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((pending.size() != 0 || rspq.size() != 0 || !local_cs_n) && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle_bounded", 32'(k < 600), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Responder plus per-cycle compare against the model queues.
  txn_t cur;
  bit   in_txn = 1'b0;
  int   low_cnt = 0;
  logic prev_wr = 1'b0;
  logic [9:0] exp_r;

  always @(negedge clk) begin
    if (rst) begin
      in_txn      = 1'b0;
      low_cnt     = 0;
      prev_wr     = 1'b0;
      local_ack_n = 1'b1;
      local_rdata = 8'hEE;
    end else begin
      if (rsp_out_wr) begin
        check("rsp_single_pulse", 32'(prev_wr), 32'd0);
        check("rsp_expected", 32'(rspq.size() != 0), 32'd1);
        if (rspq.size() != 0) begin
          exp_r = rspq.pop_front();
          check("rsp_value", 32'(rsp_out), 32'(exp_r));
        end
      end
      prev_wr = rsp_out_wr;
      if (!local_cs_n) begin
        if (!in_txn) begin
          check("cs_has_cmd", 32'(pending.size() != 0), 32'd1);
          if (pending.size() != 0) cur = pending.pop_front();
          else begin
            cur.rw = 1'b0; cur.addr = '0; cur.wdata = '0; cur.delay = 0; cur.rdata = '0;
          end
          in_txn  = 1'b1;
          low_cnt = 0;
        end
        low_cnt++;
        check("bus_rw", 32'(local_rw), 32'(cur.rw));
        check("bus_addr", 32'(local_addr), 32'(cur.addr));
        check("bus_wdata", 32'(local_wdata), 32'(cur.wdata));
        if (cur.delay > 0 && low_cnt == cur.delay) begin
          local_ack_n = 1'b0;
          local_rdata = cur.rdata;
        end
      end else begin
        if (in_txn) begin
          in_txn = 1'b0;
          check("cs_low_len", 32'(low_cnt), 32'(exp_low(cur.delay)));
          check("rsp_with_cs_rise", 32'(rsp_out_wr), 32'd1);
        end
        if (!local_ack_n) begin
          local_ack_n = 1'b1;
          local_rdata = 8'hEE;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, expected end before 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] v;
    int k;
    rst        = 1'b1;
    cmd_in_wr  = 1'b0;
    cmd_in     = '0;
    rsp_in_alf = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cs_n", 32'(local_cs_n), 32'd1);
    check("rst_rw", 32'(local_rw), 32'd1);
    check("rst_addr", 32'(local_addr), 32'd0);
    check("rst_wdata", 32'(local_wdata), 32'd0);
    check("rst_rsp_wr", 32'(rsp_out_wr), 32'd0);
    check("rst_rsp", 32'(rsp_out), 32'd0);
    check("rst_alf", 32'(cmd_out_alf), 32'd0);
    rst = 1'b0;

    // Write, ack 3 cycles into cs_n low.
    push(1'b0, 22'h00123, 8'hA5, 3, 8'h77);
    end_push();
    wait_rsp(v);
    check("t1_rsp_literal", 32'(v), 32'h000);
    wait_idle();

    // Read at top address; cs_n falls two edges after the command edge.
    push(1'b1, 22'h3FFFFF, 8'h00, 2, 8'h5A);
    @(negedge clk);
    cmd_in_wr = 1'b0;
    check("lat_after_n", 32'(local_cs_n), 32'd1);
    @(negedge clk);
    check("lat_after_n1", 32'(local_cs_n), 32'd1);
    @(negedge clk);
    check("lat_after_n2", 32'(local_cs_n), 32'd0);
    wait_rsp(v);
    check("t2_rsp_literal", 32'(v), 32'h15A);
    wait_idle();

    // Late acks around the timeout boundary, back-to-back.
    push(1'b1, 22'h2AAAAA, 8'h11, TO - 1, 8'hC3);
    push(1'b0, 22'h155555, 8'h3C, TO, 8'h99);
    end_push();
    wait_idle();

`ifdef LOCALBUS_TIMEOUT_EN
    push(1'b1, 22'h0ABCDE, 8'h00, -1, 8'h00);
    push(1'b0, 22'h000001, 8'h42, 1, 8'h00);
    end_push();
    wait_rsp(v);
    check("t4_timeout_literal", 32'(v), 32'h300);
    wait_idle();
`endif

    // Fill with the sink backed up: almost-full at 14, 17th command dropped.
    rsp_in_alf = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i > 0) check("fill_alf", 32'(cmd_out_alf), 32'(i >= 14));
      drive(1'(i % 2), 22'(i * 32'h1111 + 32'h10), 8'(i * 5), (i % 3) + 1, 8'(8'h30 + i), i < 16);
    end
    @(negedge clk);
    cmd_in_wr = 1'b0;
    check("fill_alf_full", 32'(cmd_out_alf), 32'd1);
    @(negedge clk);
    check("fill_no_cs", 32'(local_cs_n), 32'd1);
    rsp_in_alf = 1'b0;
    wait_idle();
    check("drain_alf", 32'(cmd_out_alf), 32'd0);

    // Sink almost-full holds off two queued commands.
    rsp_in_alf = 1'b1;
    push(1'b1, 22'h000AAA, 8'h01, 1, 8'hB1);
    push(1'b0, 22'h000BBB, 8'h02, 2, 8'hB2);
    end_push();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("alf_hold_cs", 32'(local_cs_n), 32'd1);
    end
    rsp_in_alf = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a transaction with commands still queued.
    push(1'b1, 22'h123456, 8'h00, 20, 8'h55);
    push(1'b0, 22'h000222, 8'h22, 1, 8'h00);
    push(1'b0, 22'h000333, 8'h33, 1, 8'h00);
    end_push();
    k = 0;
    while (local_cs_n && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_test_cs_low", 32'(local_cs_n), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    pending.delete();
    rspq.delete();
    #1;
    check("rst_async_cs_n", 32'(local_cs_n), 32'd1);
    check("rst_async_rsp_wr", 32'(rsp_out_wr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(local_cs_n), 32'd1);
    end
    push(1'b1, 22'h0000F0, 8'h00, 1, 8'h3E);
    end_push();
    wait_idle();

    check("end_rsp_queue", 32'(rspq.size()), 32'd0);
    check("end_pending", 32'(pending.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
